wf_rr_arbiter: RTL and testbench
================================

// Module: wf_rr_arbiter
// PURPOSE
//  Round-robin arbiter over the 40 wavefront slots of a compute unit. Each cycle it selects one
//  requesting slot, starting the search just after the last accepted winner. It presents the
//  winner to the consumer (issue/fetch stage) over a valid/ready handshake and holds it stable
//  until accepted. It replaces the fixed lowest-index priority pick, so no slot starves.
// PARAMETERS
//  NUM_WF   40  number of wavefront slots / request lines
//  ID_W     6   width of slot id; must satisfy 2**ID_W >= NUM_WF
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst_n         in   1       reset, synchronous, active-low
//  req_valid     in   NUM_WF  bit i = slot i requests
//  arb_en        in   1       1 = arbitration allowed; 0 = no new grant is launched
//  flush         in   1       drop any pending grant, return pointer to slot 0
//  grant_ready   in   1       consumer accepts current grant this cycle
//  grant_valid   out  1       grant_id/grant_onehot are valid
//  grant_id      out  ID_W    winning slot index
//  grant_onehot  out  NUM_WF  one-hot of grant_id; all zero when grant_valid=0
//  grant_count   out  16      number of accepted grants since reset, wraps at 2**16
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): grant_valid=0, grant_id=0, grant_onehot=0, grant_count=0,
//    last_ptr=NUM_WF-1 (so first search starts at slot 0), state=IDLE. Reset wins over all inputs.
//  - Search: the candidate order is (last_ptr+1) mod NUM_WF, +2, ..., last_ptr, wrapping
//    through index NUM_WF-1 to 0. The winner is the first candidate with req_valid set.
//    Modulo arithmetic is on ID_W bits with explicit wrap at NUM_WF, not at 2**ID_W.
//  - Outputs are registered: the winner appears one cycle after the sampled request.
//  - FSM, 2 states:
//    IDLE:  if arb_en && |req_valid && !flush, then register winner, grant_valid<=1, go GRANT.
//           Otherwise remain in IDLE with outputs 0.
//    GRANT: grant_id and grant_onehot are held stable while grant_ready=0, independent of
//           req_valid changes. A requester must not drop its request while granted; dropping
//           it does not revoke the grant.
//           On grant_ready=1 (handshake): last_ptr<=grant_id, grant_count<=grant_count+1. Then:
//             - if arb_en and any req_valid bit other than the accepted slot is set, register the
//               next winner in the same cycle (searching from grant_id+1), stay in GRANT;
//               sustained throughput is 1 grant/cycle;
//             - else grant_valid<=0, go IDLE.
//           The accepted slot is excluded from this back-to-back search. It can win again only
//           after one IDLE cycle, or after other slots have been served.
//  - arb_en=0 in GRANT: the pending grant stays valid until accepted, but no follow-on grant
//    is launched.
//  - flush=1 (any state): next cycle grant_valid=0, grant_onehot=0, last_ptr=NUM_WF-1,
//    state=IDLE. A handshake in the same cycle as flush is not counted. Flush beats grant_ready.
//  - Single requester: granted repeatedly, at most every other cycle (IDLE gap).
//  - No requesters: grant_valid stays 0. grant_id keeps its last value; its value is don't-care
//    while invalid.
//  - grant_onehot is always exactly one-hot when grant_valid=1, and equals 1<<grant_id.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with req_valid=all ones -> grant_valid=0, grant_count=0;
//    release -> first grant_id=0 one cycle later.
//  2 Rotation: req_valid={bits 3,17,39}, grant_ready=1 -> grants 3,17,39,3,17 on consecutive
//    cycles; grant_count=5.
//  3 Wrap: last accepted=39, req_valid={bits 0,38} -> next grant_id=0, then 38.
//  4 Back-pressure: grant 5 pending, grant_ready=0 for 4 cycles while req 2 rises -> grant_id
//    stays 5, onehot stays 1<<5; on accept, next grant is 2 (via wrap).
//  5 Flush: grant 12 pending, flush=1 together with grant_ready=1 -> grant_valid=0 next cycle,
//    grant_count unchanged; req_valid=all ones -> next grant 0.
//  6 Single slot 7 always requesting, grant_ready=1 -> grant_valid toggles 1,0,1,0 with id 7;
//    arb_en=0 -> no grant launched.

Source files
------------

// File: rtl/wf_rr_arbiter.sv
// Round-robin arbiter across the wavefront slots of a compute unit.
// Registered winner is presented over valid/ready and held stable until accepted.
module wf_rr_arbiter #(
  parameter int unsigned NUM_WF = 40,
  parameter int unsigned ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_WF-1:0] req_valid,
  input  logic              arb_en,
  input  logic              flush,
  input  logic              grant_ready,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic [NUM_WF-1:0] grant_onehot,
  output logic [15:0]       grant_count
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [ID_W-1:0] LAST_SLOT = ID_W'(NUM_WF - 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_last_ptr;
  logic              r_grant_valid;
  logic [ID_W-1:0]   r_grant_id;
  logic [NUM_WF-1:0] r_grant_onehot;
  logic [15:0]       r_grant_count;

  logic [ID_W-1:0]   w_base;
  logic [NUM_WF-1:0] w_mask;
  logic              w_found;
  logic [ID_W-1:0]   w_win_id;
  logic [NUM_WF-1:0] w_win_onehot;
  int unsigned       w_idx;

  // In GRANT the search is the back-to-back one: it starts after the slot
  // being accepted and excludes it, so it lands last in the order and is skipped.
  always_comb begin
    w_base   = (r_state == ST_GRANT) ? r_grant_id : r_last_ptr;
    w_mask   = req_valid;
    if (r_state == ST_GRANT)
      w_mask = req_valid & ~r_grant_onehot;
    w_found  = 1'b0;
    w_win_id = '0;
    w_idx    = 0;
    for (int unsigned off = 1; off <= NUM_WF; off++) begin
      w_idx = 32'(w_base) + off;
      if (w_idx >= NUM_WF)
        w_idx = w_idx - NUM_WF;
      if (!w_found && w_mask[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = ID_W'(w_idx);
      end
    end
    w_win_onehot = NUM_WF'(1) << w_win_id;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_last_ptr     <= LAST_SLOT;
      r_grant_valid  <= 1'b0;
      r_grant_id     <= '0;
      r_grant_onehot <= '0;
      r_grant_count  <= '0;
    end else if (flush) begin
      r_state        <= ST_IDLE;
      r_last_ptr     <= LAST_SLOT;
      r_grant_valid  <= 1'b0;
      r_grant_onehot <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arb_en && w_found) begin
            r_grant_id     <= w_win_id;
            r_grant_onehot <= w_win_onehot;
            r_grant_valid  <= 1'b1;
            r_state        <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (grant_ready) begin
            r_last_ptr    <= r_grant_id;
            r_grant_count <= r_grant_count + 16'd1;
            if (arb_en && w_found) begin
              r_grant_id     <= w_win_id;
              r_grant_onehot <= w_win_onehot;
            end else begin
              r_grant_valid  <= 1'b0;
              r_grant_onehot <= '0;
              r_state        <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_grant_valid  <= 1'b0;
          r_grant_onehot <= '0;
        end
      endcase
    end
  end

  assign grant_valid  = r_grant_valid;
  assign grant_id     = r_grant_id;
  assign grant_onehot = r_grant_onehot;
  assign grant_count  = r_grant_count;

endmodule

// File: tb/tb_wf_rr_arbiter.sv
// Directed bench for wf_rr_arbiter: accepted grants are checked by a scoreboard
// monitor, state-like properties (valid, count, stability) by direct checks.
module tb_wf_rr_arbiter;

  localparam int unsigned NUM_WF = 40;
  localparam int unsigned ID_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NUM_WF-1:0] req_valid;
  logic              arb_en;
  logic              flush;
  logic              grant_ready;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_id;
  logic [NUM_WF-1:0] grant_onehot;
  logic [15:0]       grant_count;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned exp_q[$];

  wf_rr_arbiter #(.NUM_WF(NUM_WF), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .arb_en       (arb_en),
    .flush        (flush),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .grant_count  (grant_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_WF-1:0] bit_of(input int unsigned i);
    logic [NUM_WF-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A handshake is completed at the next rising edge; flush cancels it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && grant_valid === 1'b1 && grant_ready === 1'b1 && flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got grant %0d, expected none", grant_id);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        chk("sb_grant_id", 64'(grant_id), 64'(e));
        chk("sb_grant_onehot", 64'(grant_onehot), 64'(bit_of(e)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = '1; arb_en = 1'b1; flush = 1'b0; grant_ready = 1'b0;

    // 1 reset with all requesters active
    repeat (3) begin
      tick();
      chk("rst_valid", 64'(grant_valid), 64'd0);
      chk("rst_count", 64'(grant_count), 64'd0);
      chk("rst_onehot", 64'(grant_onehot), 64'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("first_valid", 64'(grant_valid), 64'd1);
    chk("first_id", 64'(grant_id), 64'd0);
    flush = 1'b1; req_valid = '0;
    tick();
    flush = 1'b0;
    chk("flush0_valid", 64'(grant_valid), 64'd0);

    // 2 rotation over slots 3,17,39
    req_valid = bit_of(3) | bit_of(17) | bit_of(39);
    grant_ready = 1'b1;
    exp_q.push_back(3); exp_q.push_back(17); exp_q.push_back(39);
    exp_q.push_back(3); exp_q.push_back(17);
    repeat (5) tick();
    tick();
    grant_ready = 1'b0; req_valid = '0;
    chk("rot_count", 64'(grant_count), 64'd5);
    chk("rot_pending_id", 64'(grant_id), 64'd39);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("rot_flush_count", 64'(grant_count), 64'd5);

    // 3 wrap after accepting 39
    req_valid = bit_of(39); grant_ready = 1'b1;
    exp_q.push_back(39);
    tick();
    tick();
    chk("wrap_idle", 64'(grant_valid), 64'd0);
    req_valid = bit_of(0) | bit_of(38);
    exp_q.push_back(0); exp_q.push_back(38);
    tick();
    chk("wrap_first", 64'(grant_id), 64'd0);
    tick();
    req_valid = '0;
    chk("wrap_second", 64'(grant_id), 64'd38);
    tick();
    chk("wrap_idle2", 64'(grant_valid), 64'd0);
    chk("wrap_count", 64'(grant_count), 64'd8);

    // 4 back-pressure: grant 5 held while slot 2 requests
    req_valid = bit_of(5); grant_ready = 1'b0;
    tick();
    req_valid = bit_of(5) | bit_of(2);
    repeat (4) begin
      tick();
      chk("bp_valid", 64'(grant_valid), 64'd1);
      chk("bp_id", 64'(grant_id), 64'd5);
      chk("bp_onehot", 64'(grant_onehot), 64'(bit_of(5)));
    end
    grant_ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(2);
    tick();
    req_valid = '0;
    chk("bp_next", 64'(grant_id), 64'd2);
    tick();
    chk("bp_idle", 64'(grant_valid), 64'd0);
    chk("bp_count", 64'(grant_count), 64'd10);

    // 5 flush beats a same-cycle handshake
    req_valid = bit_of(12); grant_ready = 1'b0;
    tick();
    chk("fl_pending", 64'(grant_id), 64'd12);
    flush = 1'b1; grant_ready = 1'b1; req_valid = '0;
    tick();
    flush = 1'b0; grant_ready = 1'b0;
    chk("fl_valid", 64'(grant_valid), 64'd0);
    chk("fl_onehot", 64'(grant_onehot), 64'd0);
    chk("fl_count", 64'(grant_count), 64'd10);
    req_valid = '1; grant_ready = 1'b1;
    exp_q.push_back(0);
    tick();
    req_valid = '0;
    chk("fl_restart", 64'(grant_id), 64'd0);
    tick();
    chk("fl_idle", 64'(grant_valid), 64'd0);
    chk("fl_count2", 64'(grant_count), 64'd11);

    // 6 single requester alternates with an IDLE gap; arb_en=0 stops launches
    req_valid = bit_of(7); grant_ready = 1'b1;
    exp_q.push_back(7); exp_q.push_back(7);
    tick(); chk("single_v1", 64'(grant_valid), 64'd1); chk("single_id", 64'(grant_id), 64'd7);
    tick(); chk("single_v2", 64'(grant_valid), 64'd0);
    tick(); chk("single_v3", 64'(grant_valid), 64'd1);
    tick(); chk("single_v4", 64'(grant_valid), 64'd0);
    arb_en = 1'b0;
    repeat (2) begin
      tick();
      chk("arb_dis_valid", 64'(grant_valid), 64'd0);
    end
    chk("single_count", 64'(grant_count), 64'd13);
    req_valid = '0; grant_ready = 1'b0;
    tick();

    chk("sb_leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
